// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage payload widths, bubble encodings and field offsets
package pipe_pkg;
  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 64;
  localparam int EX_MEM_W = 48;
  localparam int MEM_WB_W = 40;
  localparam logic [3:0] ALU_OP_NOP = 4'd11;
  localparam int ALU_OP_LSB = 0;
  localparam int ALU_OP_W   = 4;
  localparam int REG_WE_BIT = 4;
  localparam int MEM_RE_BIT = 5;
  localparam int MEM_WE_BIT = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_W       = 5;
  localparam int IMM_LSB    = 12;
  localparam int IMM_W      = 32;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b10,
    ST_FULL  = 2'b11
  } occ_state_e;
endpackage

// File: rtl/pipe_stage_skid_buffer_if.sv
// pipe_stage_skid_buffer_if: valid/ready handshake carrying one packed payload word
interface pipe_stage_skid_buffer_if
  import pipe_pkg::*;
#(parameter int DATA_W = IF_ID_W);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one payload register with valid bit, falling-edge load/clear
module pipe_entry_reg #(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              v,
  output logic [DATA_W-1:0] q
);
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      v <= 1'b0;
      q <= BUBBLE;
    end else if (clear) begin
      v <= 1'b0;
      q <= BUBBLE;
    end else if (load) begin
      v <= 1'b1;
      q <= d;
    end
  end
endmodule

// File: rtl/pipe_stage_skid_buffer.sv
// pipe_stage_skid_buffer: inter-stage buffer with optional skid entry, flush and stall
module pipe_stage_skid_buffer
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] BUBBLE  = '0,
  parameter bit                SKID_EN = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            stall,
  input  logic                            flush,
  pipe_stage_skid_buffer_if.slave         up,
  pipe_stage_skid_buffer_if.master        dn,
  output logic [1:0]                      occupancy
);
  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_d, skid_d;
  logic              acc, pop;
  logic              main_load, main_clr, skid_load, skid_clr;
  occ_state_e        state;
  assign state     = occ_state_e'({main_v, skid_v});
  // with the skid entry, in_ready depends only on local state, never on out_ready
  assign up.ready  = reset & !stall & (SKID_EN ? !skid_v : (dn.ready | !main_v));
  assign dn.valid  = !stall & main_v;
  assign dn.data   = dn.valid ? main_d : BUBBLE;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
  assign acc       = up.valid & up.ready;
  assign pop       = dn.valid & dn.ready;
  assign main_load = (acc & ((state == ST_EMPTY) | pop)) | ((state == ST_FULL) & pop);
  assign main_clr  = flush | ((state == ST_HALF) & pop & !acc);
  assign skid_load = SKID_EN && acc && (state == ST_HALF) && !pop;
  assign skid_clr  = flush | ((state == ST_FULL) & pop);
  pipe_entry_reg #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clr),
    .d     (skid_v ? skid_d : up.data),
    .v     (main_v),
    .q     (main_d)
  );
  pipe_entry_reg #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (up.data),
    .v     (skid_v),
    .q     (skid_d)
  );
endmodule

// File: tb/tb_pipe_stage_skid_buffer.sv
// tb_pipe_stage_skid_buffer: directed scoreboard bench for skid and single-register variants
module tb_pipe_stage_skid_buffer;
  localparam logic [15:0] BUB = 16'h000B;
  logic clk = 1'b1, reset = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [1:0] a_occ, b_occ;
  int compared = 0, mismatched = 0;
  logic [15:0] sb[$];
  always #5 clk = ~clk;
  pipe_stage_skid_buffer_if #(.DATA_W(16)) a_up(), a_dn(), b_up(), b_dn();
  pipe_stage_skid_buffer #(.DATA_W(16), .BUBBLE(BUB), .SKID_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .up(a_up), .dn(a_dn), .occupancy(a_occ));
  pipe_stage_skid_buffer #(.DATA_W(16), .BUBBLE(BUB), .SKID_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .up(b_up), .dn(b_dn), .occupancy(b_occ));
  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  // handshakes are resolved just before the falling edge; flush drops everything stored
  task automatic tick();
    logic [15:0] exp;
    #1;
    if (flush) sb.delete();
    else begin
      if (a_dn.valid && a_dn.ready) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        chk("pop_data", a_dn.data, exp);
      end
      if (a_up.valid && a_up.ready) sb.push_back(a_up.data);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask
  initial begin
    a_up.valid = 1'b1; a_up.data = 16'h1234; a_dn.ready = 1'b0;
    b_up.valid = 1'b0; b_up.data = 16'h0000; b_dn.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {15'b0, a_dn.valid}, 16'h0);
    chk("rst_out_data", a_dn.data, BUB);
    chk("rst_occ", {14'b0, a_occ}, 16'h0);
    chk("rst_in_ready", {15'b0, a_up.ready}, 16'h0);
    reset = 1'b1;
    #1 chk("rel_in_ready", {15'b0, a_up.ready}, 16'h1);
    tick();
    a_up.valid = 1'b0;
    chk("rel_out_valid", {15'b0, a_dn.valid}, 16'h1);
    chk("rel_out_data", a_dn.data, 16'h1234);
    a_dn.ready = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      a_up.valid = 1'b1;
      a_up.data  = 16'(i);
      #1 chk("stream_in_ready", {15'b0, a_up.ready}, 16'h1);
      tick();
    end
    a_up.valid = 1'b0;
    tick();
    chk("stream_occ", {14'b0, a_occ}, 16'h0);
    chk("stream_sb_empty", 16'(sb.size()), 16'h0);
    a_dn.ready = 1'b0; a_up.valid = 1'b1; a_up.data = 16'hAAAA;
    tick();
    a_up.data = 16'hBBBB;
    tick();
    a_up.data = 16'hCCCC;
    #1 chk("bp_occ_full", {14'b0, a_occ}, 16'h2);
    chk("bp_in_ready", {15'b0, a_up.ready}, 16'h0);
    tick();
    chk("bp_held_occ", {14'b0, a_occ}, 16'h2);
    a_dn.ready = 1'b1;
    tick();
    chk("bp_ready_reopen", {15'b0, a_up.ready}, 16'h1);
    tick();
    a_up.valid = 1'b0;
    tick();
    chk("bp_drain_occ", {14'b0, a_occ}, 16'h0);
    chk("bp_sb_empty", 16'(sb.size()), 16'h0);
    a_dn.ready = 1'b0; a_up.valid = 1'b1; a_up.data = 16'hAAAA;
    tick();
    a_up.data = 16'hBBBB;
    tick();
    #1 chk("fl_pre_occ", {14'b0, a_occ}, 16'h2);
    flush = 1'b1; a_up.data = 16'hDDDD;
    tick();
    flush = 1'b0; a_up.valid = 1'b0;
    #1 chk("fl_occ", {14'b0, a_occ}, 16'h0);
    chk("fl_out_valid", {15'b0, a_dn.valid}, 16'h0);
    chk("fl_out_data", a_dn.data, BUB);
    a_dn.ready = 1'b1;
    repeat (2) tick();
    a_dn.ready = 1'b0; a_up.valid = 1'b1; a_up.data = 16'h5555;
    tick();
    a_up.data = 16'h7777; stall = 1'b1; a_dn.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("st_in_ready", {15'b0, a_up.ready}, 16'h0);
      chk("st_out_valid", {15'b0, a_dn.valid}, 16'h0);
      chk("st_occ", {14'b0, a_occ}, 16'h1);
      tick();
    end
    stall = 1'b0; a_up.valid = 1'b0;
    #1 chk("st_rel_valid", {15'b0, a_dn.valid}, 16'h1);
    chk("st_rel_data", a_dn.data, 16'h5555);
    tick();
    chk("st_sb_empty", 16'(sb.size()), 16'h0);
    a_dn.ready = 1'b0;
    b_up.valid = 1'b1; b_up.data = 16'h0101;
    #1 chk("ns_in_ready_empty", {15'b0, b_up.ready}, 16'h1);
    tick();
    b_up.data = 16'h0202;
    #1 chk("ns_occ", {14'b0, b_occ}, 16'h1);
    chk("ns_in_ready_full", {15'b0, b_up.ready}, 16'h0);
    chk("ns_out_data", b_dn.data, 16'h0101);
    tick();
    chk("ns_occ_held", {14'b0, b_occ}, 16'h1);
    chk("ns_out_held", b_dn.data, 16'h0101);
    b_dn.ready = 1'b1;
    #1 chk("ns_ready_follow_hi", {15'b0, b_up.ready}, 16'h1);
    tick();
    b_up.valid = 1'b0; b_dn.ready = 1'b0;
    #1 chk("ns_out_next", b_dn.data, 16'h0202);
    chk("ns_occ_next", {14'b0, b_occ}, 16'h1);
    chk("ns_ready_follow_lo", {15'b0, b_up.ready}, 16'h0);
    b_dn.ready = 1'b1;
    #1 chk("ns_ready_follow_hi2", {15'b0, b_up.ready}, 16'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid_buffer.md
Name: pipe_stage_skid_buffer

Overview:
- Parametrised inter-stage pipeline buffer replacing the hand-written per-stage buffers (IF_ID, ID_EX, EX_MEM, MEM_WB).
- Carries one packed payload word of DATA_W bits with a valid/ready handshake.
- Two-entry skid storage lets the upstream stage keep issuing for one cycle after downstream back-pressure.
- Adds flush (bubble insertion) and global stall. Payload reverts to a NOP/bubble encoding whenever no valid entry is presented.

Parameters:
- DATA_W, 64, width of the packed payload (control + data fields of the stage).
- BUBBLE, {DATA_W{1'b0}}, payload presented when empty, flushed or reset (e.g. ALU_OP field = 4'd11 NOP).
- SKID_EN, 1, 1 = two-entry skid buffer; 0 = single register, in_ready combinationally tied to out_ready.

Ports:
- clk  input  1  stage clock; all state updates on the falling edge.
- reset  input  1  asynchronous, active-low; clears all state.
- stall  input  1  hazard-unit freeze; holds all state, forces in_ready=0 and out_valid=0.
- flush  input  1  branch/interrupt squash; discards all stored entries.
- in_valid  input  1  upstream presents a payload.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  buffer accepts in_data this cycle.
- out_valid  output  1  out_data holds a real instruction.
- out_data  output  DATA_W  head payload, or BUBBLE when out_valid=0.
- out_ready  input  1  downstream consumes the head this cycle.
- occupancy  output  2  number of stored entries (0..2; max 1 when SKID_EN=0).

Behaviour:
- Storage: main entry (main_v, main_d) and skid entry (skid_v, skid_d), updated on negedge clk.
- Reset (reset=0, any time, asynchronous):
  - main_v=skid_v=0, main_d=skid_d=BUBBLE.
  - Outputs: out_valid=0, out_data=BUBBLE, in_ready=0 while reset is asserted, occupancy=0.
- Priority per edge: reset > flush > stall > normal transfer.
- flush=1:
  - main_v=skid_v=0 and both data registers load BUBBLE.
  - Any same-cycle input is dropped, even if in_valid=1.
  - A same-cycle pop is not counted as a consumption.
- stall=1 (flush=0): all registers hold. in_ready=0 and out_valid=0 (combinational), so no transfer occurs on either side.
- Combinational outputs (stall=0):
  - in_ready = !skid_v when SKID_EN=1; in_ready = out_ready | !main_v when SKID_EN=0.
  - out_valid = main_v; out_data = main_v ? main_d : BUBBLE.
  - occupancy = main_v + skid_v.
- Handshake events: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions (SKID_EN=1), indexed by {main_v, skid_v}:
  - EMPTY {0,0}: acc -> main<=in, go HALF.
  - HALF {1,0}:
    - acc & pop -> main<=in, stay HALF.
    - acc & !pop -> skid<=in, go FULL.
    - !acc & pop -> go EMPTY.
  - FULL {1,1}: in_ready=0. pop -> main<=skid, skid_v<=0, skid_d<=BUBBLE, go HALF.
  - {0,1} is illegal and unreachable.
- Ordering: strictly FIFO; the skid entry never overtakes main.
- Latency: one falling edge from accept to out_valid. No combinational path from in_data to out_data. With SKID_EN=1 there is also no path from out_ready to in_ready.
- Throughput: one payload per cycle when out_ready=1 continuously.
- Simultaneous flush+stall: flush wins.
- Reset deasserted mid-cycle: the next falling edge operates normally from EMPTY.

Decomposition:
- Shared package pipe_pkg:
  - per-stage payload widths (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W);
  - NOP/bubble constants (ALU_OP_NOP = 4'd11, zeroed write/read enables);
  - field-offset localparams used to pack/unpack stage payloads.
- One sub-module, pipe_entry_reg: a single DATA_W register with valid bit, load/clear and async active-low reset. Instantiate twice (main, skid).
- No further hierarchy.

Test Plan (DATA_W=16, BUBBLE=16'h000B, SKID_EN=1 unless noted):
1. Reset: hold reset=0 with in_valid=1, in_data=16'h1234 -> out_valid=0, out_data=16'h000B, occupancy=0, in_ready=0. Release reset -> in_ready=1 and the next falling edge accepts 16'h1234.
2. Streaming: out_ready=1, feed 16'h0001..16'h0008 back-to-back -> outputs appear in order, each one edge after acceptance, with in_ready constantly 1.
3. Back-pressure: out_ready=0, send 16'hAAAA then 16'hBBBB -> occupancy=2, in_ready=0, a third word 16'hCCCC is held upstream. Raise out_ready -> AAAA, BBBB, CCCC delivered in order with no loss or duplication.
4. Flush: occupancy=2 (AAAA, BBBB) plus flush=1 with in_valid=1, in_data=16'hDDDD -> after the edge occupancy=0, out_data=16'h000B, DDDD never appears.
5. Stall: occupancy=1 holding 16'h5555, stall=1 for 3 edges with in_valid=1 -> in_ready=0, out_valid=0, contents unchanged. Release stall -> 16'h5555 presented.
6. SKID_EN=0: out_ready=0 with main full -> in_ready=0 and occupancy never exceeds 1. Toggle out_ready=1 -> in_ready follows out_ready in the same cycle.
